// File: rtl/selector_pkg.sv
// selector: shared decoder selector types for the memory stage.
// Holds load/store kind enums, the mem_access_unit FSM state enum,
// byte-enable constants, and the alignment helpers used by mem_access_unit.
package selector;

    // Load kind produced by the main decoder
    typedef enum logic [2:0] {
        MEM_READ_NCARE       = 3'd0,
        MEM_READ_BYTE        = 3'd1,
        MEM_READ_HALF        = 3'd2,
        MEM_READ_WORD        = 3'd3,
        MEM_READ_UNSIGN_BYTE = 3'd4,
        MEM_READ_UNSIGN_HALF = 3'd5,
        MEM_READ_LWL         = 3'd6,
        MEM_READ_LWR         = 3'd7
    } mem_read_type;

    // Store kind produced by the main decoder
    typedef enum logic [2:0] {
        MEM_WRITE_NCARE = 3'd0,
        MEM_WRITE_BYTE  = 3'd1,
        MEM_WRITE_HALF  = 3'd2,
        MEM_WRITE_WORD  = 3'd3,
        MEM_WRITE_SWL   = 3'd4,
        MEM_WRITE_SWR   = 3'd5
    } mem_write_type;

    // mem_access_unit control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_access_state;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // True when a HALF access sits on an odd byte or a WORD access is not word aligned.
    // The write kind passed in must already be NCARE when a load wins priority.
    function automatic logic is_misaligned(input mem_read_type rd,
                                           input mem_write_type wr,
                                           input logic [1:0] b);
        logic mis;
        mis = 1'b0;
        case (rd)
            MEM_READ_HALF, MEM_READ_UNSIGN_HALF: mis = b[0];
            MEM_READ_WORD:                       mis = (b != 2'd0);
            MEM_READ_NCARE: begin
                case (wr)
                    MEM_WRITE_HALF: mis = b[0];
                    MEM_WRITE_WORD: mis = (b != 2'd0);
                    default:        mis = 1'b0;
                endcase
            end
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte offset with the offending low bits cleared: HALF keeps b[1], WORD uses 0.
    function automatic logic [1:0] force_align(input mem_read_type rd,
                                               input mem_write_type wr,
                                               input logic [1:0] b);
        logic [1:0] fb;
        fb = b;
        case (rd)
            MEM_READ_HALF, MEM_READ_UNSIGN_HALF: fb = {b[1], 1'b0};
            MEM_READ_WORD:                       fb = 2'd0;
            MEM_READ_NCARE: begin
                case (wr)
                    MEM_WRITE_HALF: fb = {b[1], 1'b0};
                    MEM_WRITE_WORD: fb = 2'd0;
                    default:        fb = b;
                endcase
            end
            default: fb = b;
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
// Store side turns (kind, offset, rt) into byte enables and lane data;
// load side turns (kind, offset, bus word, rt) into the writeback value.
module mem_lane_align
    import selector::*;
(
    input  mem_write_type i_st_type,
    input  logic [1:0]    i_st_b,
    input  logic [31:0]   i_st_rt,
    output logic [3:0]    o_st_be,
    output logic [31:0]   o_st_wdata,
    input  mem_read_type  i_ld_type,
    input  logic [1:0]    i_ld_b,
    input  logic [31:0]   i_ld_m,
    input  logic [31:0]   i_ld_rt,
    output logic [31:0]   o_ld_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_m[{i_ld_b, 3'b000} +: 8];
    assign w_half = i_ld_m[{i_ld_b[1], 4'b0000} +: 16];

    // Store lane steering: byte enables and replicated / shifted data
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_st_be    = BE_NONE;
        o_st_wdata = 32'd0;
        case (i_st_type)
            MEM_WRITE_BYTE: begin
                o_st_be    = 4'b0001 << i_st_b;
                o_st_wdata = {4{i_st_rt[7:0]}};
            end
            MEM_WRITE_HALF: begin
                o_st_be    = 4'b0011 << i_st_b;
                o_st_wdata = {2{i_st_rt[15:0]}};
            end
            MEM_WRITE_WORD: begin
                o_st_be    = BE_ALL;
                o_st_wdata = i_st_rt;
            end
            MEM_WRITE_SWL: begin
                case (i_st_b)
                    2'd0:    begin o_st_be = 4'b0001; o_st_wdata = {24'd0, i_st_rt[31:24]}; end
                    2'd1:    begin o_st_be = 4'b0011; o_st_wdata = {16'd0, i_st_rt[31:16]}; end
                    2'd2:    begin o_st_be = 4'b0111; o_st_wdata = {8'd0,  i_st_rt[31:8]};  end
                    default: begin o_st_be = 4'b1111; o_st_wdata = i_st_rt;                 end
                endcase
            end
            MEM_WRITE_SWR: begin
                case (i_st_b)
                    2'd0:    begin o_st_be = 4'b1111; o_st_wdata = i_st_rt;                 end
                    2'd1:    begin o_st_be = 4'b1110; o_st_wdata = {i_st_rt[23:0], 8'd0};  end
                    2'd2:    begin o_st_be = 4'b1100; o_st_wdata = {i_st_rt[15:0], 16'd0}; end
                    default: begin o_st_be = 4'b1000; o_st_wdata = {i_st_rt[7:0], 24'd0};  end
                endcase
            end
            default: begin
                o_st_be    = BE_NONE;
                o_st_wdata = 32'd0;
            end
        endcase
    end

    // Load extraction: extend sub-word loads, merge LWL/LWR with rt
    always_comb begin
        o_ld_rdata = i_ld_m;
        case (i_ld_type)
            MEM_READ_BYTE:        o_ld_rdata = {{24{w_byte[7]}}, w_byte};
            MEM_READ_UNSIGN_BYTE: o_ld_rdata = {24'd0, w_byte};
            MEM_READ_HALF:        o_ld_rdata = {{16{w_half[15]}}, w_half};
            MEM_READ_UNSIGN_HALF: o_ld_rdata = {16'd0, w_half};
            MEM_READ_WORD:        o_ld_rdata = i_ld_m;
            MEM_READ_LWL: begin
                case (i_ld_b)
                    2'd0:    o_ld_rdata = {i_ld_m[7:0],  i_ld_rt[23:0]};
                    2'd1:    o_ld_rdata = {i_ld_m[15:0], i_ld_rt[15:0]};
                    2'd2:    o_ld_rdata = {i_ld_m[23:0], i_ld_rt[7:0]};
                    default: o_ld_rdata = i_ld_m;
                endcase
            end
            MEM_READ_LWR: begin
                case (i_ld_b)
                    2'd0:    o_ld_rdata = i_ld_m;
                    2'd1:    o_ld_rdata = {i_ld_rt[31:24], i_ld_m[31:8]};
                    2'd2:    o_ld_rdata = {i_ld_rt[31:16], i_ld_m[31:16]};
                    default: o_ld_rdata = {i_ld_rt[31:8],  i_ld_m[31:24]};
                endcase
            end
            default: o_ld_rdata = i_ld_m;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine with a req/ready word bus.
// Captures the request on accept, drives registered bus outputs, and returns
// the extended/merged load word with a one-cycle done pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses raise
// addr_error and skip the bus; otherwise the low offset bits are ignored).
module mem_access_unit
    import selector::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  mem_read_type      read_type,
    input  mem_write_type     write_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_value,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_error
);

    mem_access_state r_state;
    mem_read_type    r_rd_type;
    logic [1:0]      r_b;
    logic [31:0]     r_rt;
    logic            r_is_load;

    mem_write_type   w_wr_eff;
    logic            w_is_load;
    logic            w_none;
    logic            w_misaligned;
    logic [1:0]      w_b_eff;
    logic [3:0]      w_st_be;
    logic [31:0]     w_st_wdata;
    logic [31:0]     w_ld_rdata;

    // A load wins over a simultaneous store
    assign w_is_load = (read_type != MEM_READ_NCARE);
    assign w_wr_eff  = w_is_load ? MEM_WRITE_NCARE : write_type;
    assign w_none    = !w_is_load && (write_type == MEM_WRITE_NCARE);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(read_type, w_wr_eff, addr[1:0]);
    assign w_b_eff      = addr[1:0];
`else
    assign w_misaligned = 1'b0;
    assign w_b_eff      = force_align(read_type, w_wr_eff, addr[1:0]);
`endif

    mem_lane_align u_lane_align (
        .i_st_type  (w_wr_eff),
        .i_st_b     (w_b_eff),
        .i_st_rt    (rt_value),
        .o_st_be    (w_st_be),
        .o_st_wdata (w_st_wdata),
        .i_ld_type  (r_rd_type),
        .i_ld_b     (r_b),
        .i_ld_m     (bus_rdata),
        .i_ld_rt    (r_rt),
        .o_ld_rdata (w_ld_rdata)
    );

    // Control FSM with request capture and registered bus / status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rd_type  <= MEM_READ_NCARE;
            r_b        <= 2'd0;
            r_rt       <= 32'd0;
            r_is_load  <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= BE_NONE;
            bus_wdata  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            addr_error <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rd_type <= read_type;
                        r_b       <= w_b_eff;
                        r_rt      <= rt_value;
                        r_is_load <= w_is_load;
                        if (w_misaligned || w_none) begin
                            r_state    <= DONE;
                            done       <= 1'b1;
                            addr_error <= w_misaligned;
                        end else begin
                            r_state   <= REQ;
                            bus_req   <= 1'b1;
                            busy      <= 1'b1;
                            bus_we    <= !w_is_load;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= w_is_load ? BE_ALL : w_st_be;
                            bus_wdata <= w_is_load ? 32'd0 : w_st_wdata;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        r_state <= DONE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (r_is_load) begin
                            rdata <= w_ld_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    done       <= 1'b0;
                    addr_error <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized bench for mem_access_unit
// with a byte/shift-arithmetic reference model of the load/store rules.
module tb_mem_access_unit;
    import selector::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    mem_read_type  read_type;
    mem_write_type write_type;
    logic [31:0]   addr;
    logic [31:0]   rt_value;
    logic          bus_req;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_ready;
    logic [31:0]   bus_rdata;
    logic          busy;
    logic          done;
    logic [31:0]   rdata;
    logic          addr_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .read_type  (read_type),
        .write_type (write_type),
        .addr       (addr),
        .rt_value   (rt_value),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .addr_error (addr_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_misaligned(mem_read_type r, mem_write_type w, logic [1:0] b);
        bit half_k = (r == MEM_READ_HALF) || (r == MEM_READ_UNSIGN_HALF) ||
                     (r == MEM_READ_NCARE && w == MEM_WRITE_HALF);
        bit word_k = (r == MEM_READ_WORD) || (r == MEM_READ_NCARE && w == MEM_WRITE_WORD);
        return (half_k && (b % 2 != 0)) || (word_k && b != 0);
    endfunction

    function automatic logic [1:0] m_offset(mem_read_type r, mem_write_type w, logic [1:0] b);
        bit half_k = (r == MEM_READ_HALF) || (r == MEM_READ_UNSIGN_HALF) ||
                     (r == MEM_READ_NCARE && w == MEM_WRITE_HALF);
        bit word_k = (r == MEM_READ_WORD) || (r == MEM_READ_NCARE && w == MEM_WRITE_WORD);
`ifdef MEM_ALIGN_CHECK_EN
        return b;
`else
        if (word_k) return 2'd0;
        if (half_k) return b & 2'b10;
        return b;
`endif
    endfunction

    function automatic logic [31:0] m_load(mem_read_type r, int b, logic [31:0] m, logic [31:0] rt);
        logic [31:0] byt;
        logic [31:0] hw;
        byt = (m >> (8 * b)) & 32'hFF;
        hw  = (m >> (8 * b)) & 32'hFFFF;
        case (r)
            MEM_READ_BYTE:        return (byt >= 32'h80) ? (byt | 32'hFFFFFF00) : byt;
            MEM_READ_UNSIGN_BYTE: return byt;
            MEM_READ_HALF:        return (hw >= 32'h8000) ? (hw | 32'hFFFF0000) : hw;
            MEM_READ_UNSIGN_HALF: return hw;
            MEM_READ_LWL:         return (m << (8 * (3 - b))) | (rt & ((32'hFFFFFFFF >> (8 * b)) >> 8));
            MEM_READ_LWR:         return (m >> (8 * b)) | (rt & ~(32'hFFFFFFFF >> (8 * b)));
            default:              return m;
        endcase
    endfunction

    task automatic m_store(input mem_write_type w, input int b, input logic [31:0] rt,
                           output logic [3:0] be, output logic [31:0] wd);
        case (w)
            MEM_WRITE_BYTE: begin be = 4'(1 << b); wd = (rt & 32'hFF) * 32'h01010101; end
            MEM_WRITE_HALF: begin be = 4'(3 << b); wd = (rt & 32'hFFFF) * 32'h00010001; end
            MEM_WRITE_SWL:  begin be = 4'(15 >> (3 - b)); wd = rt >> (8 * (3 - b)); end
            MEM_WRITE_SWR:  begin be = 4'(15 << b); wd = rt << (8 * b); end
            default:        begin be = 4'hF; wd = rt; end
        endcase
    endtask

    // Issue one operation from IDLE (caller sits just after a rising edge)
    task automatic run_op(input string tag, input mem_read_type r, input mem_write_type w,
                          input logic [31:0] a, input logic [31:0] rtv,
                          input int delay, input logic [31:0] m);
        mem_write_type w_eff;
        bit            mis;
        bit            nobus;
        logic [1:0]    b;
        logic [3:0]    exp_be;
        logic [31:0]   exp_wd;
        w_eff = (r != MEM_READ_NCARE) ? MEM_WRITE_NCARE : w;
`ifdef MEM_ALIGN_CHECK_EN
        mis = m_misaligned(r, w_eff, a[1:0]);
`else
        mis = 1'b0;
`endif
        nobus = mis || (r == MEM_READ_NCARE && w == MEM_WRITE_NCARE);
        b = m_offset(r, w_eff, a[1:0]);
        m_store(w_eff, int'(b), rtv, exp_be, exp_wd);

        start = 1'b1; read_type = r; write_type = w; addr = a; rt_value = rtv;
        @(posedge clk); #1;
        start      = 1'b0;
        read_type  = mem_read_type'($urandom_range(0, 7));
        write_type = mem_write_type'($urandom_range(0, 5));
        addr       = $urandom;
        rt_value   = $urandom;

        if (nobus) begin
            check({tag, " nobus done"}, 32'(done), 32'd1);
            check({tag, " nobus addr_error"}, 32'(addr_error), 32'(mis));
            check({tag, " nobus bus_req"}, 32'(bus_req), 32'd0);
            check({tag, " nobus rdata kept"}, rdata, model_rdata);
        end else begin
            check({tag, " bus_req"}, 32'(bus_req), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " bus_we"}, 32'(bus_we), 32'(r == MEM_READ_NCARE));
            check({tag, " bus_addr"}, bus_addr, a & 32'hFFFFFFFC);
            check({tag, " bus_be"}, 32'(bus_be), (r != MEM_READ_NCARE) ? 32'hF : 32'(exp_be));
            if (r == MEM_READ_NCARE) check({tag, " bus_wdata"}, bus_wdata, exp_wd);
            for (int i = 0; i < delay; i++) begin
                bus_ready = 1'b0;
                @(posedge clk); #1;
                check({tag, " req held"}, 32'(bus_req), 32'd1);
                check({tag, " no early done"}, 32'(done), 32'd0);
            end
            bus_ready = 1'b1;
            bus_rdata = m;
            @(posedge clk); #1;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (r != MEM_READ_NCARE) model_rdata = m_load(r, int'(b), m, rtv);
            check({tag, " done"}, 32'(done), 32'd1);
            check({tag, " busy low"}, 32'(busy), 32'd0);
            check({tag, " req low"}, 32'(bus_req), 32'd0);
            check({tag, " addr_error"}, 32'(addr_error), 32'd0);
            check({tag, " rdata"}, rdata, model_rdata);
        end
        @(posedge clk); #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; read_type = MEM_READ_NCARE; write_type = MEM_WRITE_NCARE;
        addr = 32'd0; rt_value = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
        model_rdata = 32'd0;
        #12;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset addr_error", 32'(addr_error), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_be", 32'(bus_be), 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        check("reset rdata", rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the load/store rules
        run_op("LB", MEM_READ_BYTE, MEM_WRITE_NCARE, 32'h1003, 32'h0, 0, 32'h80112233);
        run_op("SH", MEM_READ_NCARE, MEM_WRITE_HALF, 32'h2002, 32'hAAAA1234, 3, 32'h0);
        run_op("LWL", MEM_READ_LWL, MEM_WRITE_NCARE, 32'h4001, 32'hDEADBEEF, 1, 32'h44332211);
        run_op("LWR", MEM_READ_LWR, MEM_WRITE_NCARE, 32'h4002, 32'hDEADBEEF, 0, 32'h44332211);
        run_op("SWL", MEM_READ_NCARE, MEM_WRITE_SWL, 32'h5002, 32'h11223344, 0, 32'h0);
        run_op("SWR", MEM_READ_NCARE, MEM_WRITE_SWR, 32'h5001, 32'h11223344, 2, 32'h0);
        run_op("LW mis", MEM_READ_WORD, MEM_WRITE_NCARE, 32'h3001, 32'h0, 0, 32'hCAFEF00D);
        run_op("LHU mis", MEM_READ_UNSIGN_HALF, MEM_WRITE_NCARE, 32'h3003, 32'h0, 1, 32'h8765ABCD);
        run_op("SW mis", MEM_READ_NCARE, MEM_WRITE_WORD, 32'h3002, 32'h5A5A1234, 0, 32'h0);
        run_op("none", MEM_READ_NCARE, MEM_WRITE_NCARE, 32'h6000, 32'h0, 0, 32'h0);
        run_op("ld+st", MEM_READ_HALF, MEM_WRITE_WORD, 32'h7002, 32'h1, 0, 32'h9ABC0000);

        // bus_ready outside REQ must be ignored
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        check("idle ready ignored done", 32'(done), 32'd0);
        check("idle ready ignored req", 32'(bus_req), 32'd0);

        // Asynchronous reset in REQ abandons the access
        start = 1'b1; read_type = MEM_READ_WORD; write_type = MEM_WRITE_NCARE;
        addr = 32'h8000; rt_value = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        check("pre-reset req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset req", 32'(bus_req), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        model_rdata = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset done", 32'(done), 32'd0);
        run_op("after reset", MEM_READ_BYTE, MEM_WRITE_NCARE, 32'h8001, 32'h0, 0, 32'h00007F00);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            run_op("rand", mem_read_type'($urandom_range(0, 7)),
                   mem_write_type'($urandom_range(0, 5)),
                   $urandom, $urandom, int'($urandom_range(0, 3)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
